// File: rtl/db_switch_ctrl_if.sv
// Write/read request-ready handshake between a producer/consumer and db_switch_ctrl.
// Strobes are combinational in the controller; the master side only drives requests.
interface db_switch_ctrl_if;
   logic wr_req;
   logic wr_last;
   logic rd_req;
   logic wr_rdy;
   logic rd_rdy;
   logic wen_out;
   logic ren_out;

   modport master (
      output wr_req, wr_last, rd_req,
      input  wr_rdy, rd_rdy, wen_out, ren_out
   );

   modport slave (
      input  wr_req, wr_last, rd_req,
      output wr_rdy, rd_rdy, wen_out, ren_out
   );
endinterface

// File: rtl/db_switch_ctrl.sv
// Double-buffer bank-swap controller: fill one bank while the other is read, swap when both sides finish.
// Zero-latency accept (strobe = req & rdy, gated by clk_en); backpressure via wr_rdy/rd_rdy windows.
// Optional counters swap_cnt/stall_cnt appear when DB_SWITCH_CTRL_PERF_EN is defined.
module db_switch_ctrl #(
   parameter int DEPTH_W = 16,
   parameter int ITER_W  = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               clk_en,
   input  logic               flush,
   input  logic [DEPTH_W-1:0] depth,
   input  logic [ITER_W-1:0]  iter_cnt,
   db_switch_ctrl_if.slave    bus,
   output logic               switch_db,
   output logic               bank_sel,
   output logic               busy,
   output logic               done
`ifdef DB_SWITCH_CTRL_PERF_EN
   ,
   output logic [ITER_W-1:0]  swap_cnt,
   output logic [ITER_W-1:0]  stall_cnt
`endif
);

   typedef enum logic [2:0] {IDLE, FILL, STREAM, SWAP, DRAIN} state_t;

   state_t             state_q, state_d;
   logic [DEPTH_W-1:0] wr_cnt_q, wr_cnt_d;
   logic [ITER_W-1:0]  rd_cnt_q, rd_cnt_d;
   logic               bank_q, bank_d;
   logic               last_q, last_d;

   logic               wr_open, rd_open;
   logic               wen, ren;
   logic               wr_hit, rd_hit;
   logic               wr_side_done, rd_side_done;
   logic [DEPTH_W:0]   wr_cnt_inc;
   logic [ITER_W:0]    rd_cnt_inc;

   assign wr_open = wr_cnt_q < depth;
   assign rd_open = rd_cnt_q < iter_cnt;

   // Ready windows are closed whenever clk_en is low so no strobe can fire.
   assign bus.wr_rdy = clk_en && ((state_q == FILL && wr_open) ||
                                  (state_q == STREAM && wr_open && !last_q));
   assign bus.rd_rdy = clk_en && (state_q == STREAM || state_q == DRAIN) && rd_open;

   assign wen = bus.wr_req && bus.wr_rdy;
   assign ren = bus.rd_req && bus.rd_rdy;
   assign bus.wen_out = wen;
   assign bus.ren_out = ren;

   assign wr_cnt_inc = {1'b0, wr_cnt_q} + (DEPTH_W+1)'(1);
   assign rd_cnt_inc = {1'b0, rd_cnt_q} + (ITER_W+1)'(1);
   assign wr_hit     = wen && (wr_cnt_inc == {1'b0, depth});
   assign rd_hit     = ren && (rd_cnt_inc == {1'b0, iter_cnt});

   // Completion includes an accept landing in the current cycle.
   assign wr_side_done = (wr_cnt_q == depth) || wr_hit || last_q || (wen && bus.wr_last);
   assign rd_side_done = (rd_cnt_q == iter_cnt) || rd_hit;

   assign switch_db = clk_en && !flush && (state_q == SWAP);
   assign done      = clk_en && !flush && (state_q == DRAIN) && rd_side_done;
   assign busy      = (state_q != IDLE);
   assign bank_sel  = bank_q;

   always_comb begin
      state_d  = state_q;
      wr_cnt_d = wr_cnt_q;
      rd_cnt_d = rd_cnt_q;
      bank_d   = bank_q;
      last_d   = last_q;

      if (clk_en) begin
         if (wen) wr_cnt_d = wr_cnt_q + DEPTH_W'(1);
         if (ren) rd_cnt_d = rd_cnt_q + ITER_W'(1);
         if (wen && bus.wr_last) last_d = 1'b1;

         case (state_q)
            IDLE: begin
               if (depth != '0) begin
                  state_d  = FILL;
                  wr_cnt_d = '0;
                  rd_cnt_d = '0;
                  last_d   = 1'b0;
               end
            end
            FILL: begin
               if (wr_hit || (wen && bus.wr_last)) state_d = SWAP;
            end
            STREAM: begin
               if (wr_side_done && rd_side_done) state_d = SWAP;
            end
            SWAP: begin
               bank_d   = !bank_q;
               wr_cnt_d = '0;
               rd_cnt_d = '0;
               state_d  = last_q ? DRAIN : STREAM;
            end
            DRAIN: begin
               if (rd_side_done) begin
                  state_d = IDLE;
                  last_d  = 1'b0;
               end
            end
            default: state_d = IDLE;
         endcase

         if (flush) begin
            state_d  = IDLE;
            wr_cnt_d = '0;
            rd_cnt_d = '0;
            bank_d   = 1'b0;
            last_d   = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         wr_cnt_q <= '0;
         rd_cnt_q <= '0;
         bank_q   <= 1'b0;
         last_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_cnt_q <= wr_cnt_d;
         rd_cnt_q <= rd_cnt_d;
         bank_q   <= bank_d;
         last_q   <= last_d;
      end
   end

`ifdef DB_SWITCH_CTRL_PERF_EN
   logic [ITER_W-1:0] swap_cnt_q, stall_cnt_q;
   logic              stall;

   assign stall     = clk_en && ((bus.wr_req && !bus.wr_rdy) || (bus.rd_req && !bus.rd_rdy));
   assign swap_cnt  = swap_cnt_q;
   assign stall_cnt = stall_cnt_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         swap_cnt_q  <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (clk_en && flush) swap_cnt_q <= '0;
         else if (switch_db)  swap_cnt_q <= swap_cnt_q + ITER_W'(1);
         if (stall) stall_cnt_q <= stall_cnt_q + ITER_W'(1);
      end
   end
`endif

endmodule

// File: doc/db_switch_ctrl.md
DB_SWITCH_CTRL -- requirements
Module: db_switch_ctrl

Interface
REQ-001 SHALL have parameter DEPTH_W, default 16, width of depth and write counter.
REQ-002 SHALL have parameter ITER_W, default 32, width of iter_cnt and read counter.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port clk_en  input  1  global advance enable.
REQ-006 SHALL have port flush  input  1  synchronous abort to IDLE.
REQ-007 SHALL have port depth  input  DEPTH_W  words per bank, held static while busy; 0 means disabled.
REQ-008 SHALL have port iter_cnt  input  ITER_W  reads per bank, held static while busy; 0 means no reads.
REQ-009 SHALL have ports wr_req, wr_last  input  1  write request; final write of the stream.
REQ-010 SHALL have port rd_req  input  1  read request.
REQ-011 SHALL have ports wr_rdy, rd_rdy  output  1  write/read accept windows.
REQ-012 SHALL have ports wen_out, ren_out  output  1  memory-core write/read strobes.
REQ-013 SHALL have port switch_db  output  1  one-cycle bank-swap pulse to the memory core.
REQ-014 SHALL have ports bank_sel, busy, done  output  1  current write bank; FSM not IDLE; one-cycle completion pulse.

Function
REQ-015 SHALL implement states IDLE, FILL, STREAM, SWAP, DRAIN.
REQ-016 SHALL define write acceptance as wen_out=wr_req&wr_rdy and read acceptance as ren_out=rd_req&rd_rdy, both combinational with zero latency.
REQ-017 SHALL gate every transition, counter update and output strobe (wen_out, ren_out, switch_db, done) with clk_en; when clk_en=0, state freezes and strobes are 0.
REQ-018 IDLE: SHALL move to FILL when depth!=0 and flush=0; wr_rdy=rd_rdy=0.
REQ-019 FILL: SHALL assert wr_rdy only while wr_cnt<depth, with rd_rdy=0; on the write that makes wr_cnt==depth, or on an accepted wr_last, SHALL go to SWAP.
REQ-020 STREAM: wr_rdy SHALL equal (wr_cnt<depth and no wr_last seen); rd_rdy SHALL equal (rd_cnt<iter_cnt).
REQ-021 STREAM: SHALL go to SWAP when the write side is complete (wr_cnt==depth or wr_last accepted) and the read side is complete (rd_cnt==iter_cnt), counting accepts made in the same cycle.
REQ-022 SWAP: SHALL last exactly one cycle, assert switch_db=1 with wr_rdy=rd_rdy=0, toggle bank_sel, and clear wr_cnt and rd_cnt.
REQ-023 SWAP exit: SHALL go to DRAIN if wr_last has been accepted, otherwise to STREAM.
REQ-024 DRAIN: SHALL assert rd_rdy while rd_cnt<iter_cnt, with wr_rdy=0; when rd_cnt reaches iter_cnt, SHALL pulse done for one cycle and go to IDLE.
REQ-025 Empty boundary: iter_cnt=0 SHALL make the read side complete immediately, and depth=0 SHALL hold the FSM in IDLE.
REQ-026 Counters: SHALL saturate at depth/iter_cnt and never wrap; accepted requests beyond the limit are impossible because rdy is low.
REQ-027 Flush: flush=1 with clk_en=1 SHALL return the FSM to IDLE, clear counters, wr_last flag and bank_sel, and emit no switch_db or done; flush has priority over every transition.

Reset
REQ-028 Reset low SHALL asynchronously force IDLE, wr_cnt=0, rd_cnt=0, bank_sel=0, wr_last flag=0 and all outputs 0, including mid-operation.
REQ-029 After reset deasserts, the first transition SHALL occur no earlier than the next rising edge.

Configuration
REQ-030 With macro DB_SWITCH_CTRL_PERF_EN defined, SHALL add output swap_cnt (ITER_W), incrementing on each switch_db and cleared by reset or flush, and output stall_cnt (ITER_W), incrementing each clk_en cycle with wr_req&!wr_rdy or rd_req&!rd_rdy.
REQ-031 Without DB_SWITCH_CTRL_PERF_EN, swap_cnt and stall_cnt SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-032 depth=4, iter_cnt=4, continuous wr_req/rd_req -> 4 writes, switch_db on cycle 5, bank_sel=1, then 4 writes + 4 reads per bank with switch_db between banks.
REQ-033 depth=4, iter_cnt=8, wr_last on write 10 -> swaps after writes 4 and 8, STREAM after write 10 waits for read 8, SWAP, DRAIN 8 reads, done pulse, IDLE.
REQ-034 depth=4, iter_cnt=4, clk_en low for 3 cycles during STREAM -> counters, state and bank_sel unchanged, no strobes while low.
REQ-035 depth=4, iter_cnt=0 -> switch_db every 5th cycle under continuous wr_req, ren_out never asserted.
REQ-036 flush in STREAM with wr_cnt=2 -> next cycle IDLE, bank_sel=0, no switch_db or done; reset low mid-SWAP -> all outputs 0 immediately.
